hd63701_sci_fifo: RTL and testbench

Parametrised successor to the on-chip HD63701 serial interface. Full-duplex async UART with programmable 16-bit bit-rate divider and TX/RX FIFOs of configurable depth, with overrun/framing status and a level interrupt. Sits on the core's internal register bus next to the timer and I/O port blocks, in the built-in device data selector.

---
 rtl/hd63701_sci_fifo.sv | 275 +++++++++++++++++++++++++++
 tb/tb_hd63701_sci_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd63701_sci_fifo.sv
// hd63701_sci_fifo: full-duplex UART with TX/RX FIFOs on the MCU register bus.
// Optional build macro SCI_PARITY_EN adds CTRL.PEN/PODD, the PAR state and STAT.PE;
// without it every frame is 8N1.
//
// state   | meaning
// IDLE    | line idle; TX waits for TE and data, RX waits for a falling edge
// START   | start bit (TX drives 0, RX waits to mid-bit and rejects false starts)
// DATA    | 8 data bits, LSB first
// PAR     | parity bit (only when PEN=1)
// STOP    | stop bit; RX pushes the byte, TX chains the next frame or idles
module hd63701_sci_fifo #(
  parameter logic [15:0] BASE       = 16'h0010,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd255
) (
  input  logic        mcu_clx2,
  input  logic        mcu_rst_n,
  input  logic [15:0] mcu_ad,
  input  logic        mcu_wr,
  input  logic [7:0]  mcu_do,
  input  logic        rx,
  output logic        tx,
  output logic        te,
  output logic        mcu_irq2_sci,
  output logic        en_sci,
  output logic [7:0]  iod
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PAR = 3'd3, S_STOP = 3'd4;
  localparam logic [2:0] A_CTRL = 3'd0, A_STAT = 3'd1, A_DATA = 3'd2, A_DIVL = 3'd3, A_DIVH = 3'd4;
`ifdef SCI_PARITY_EN
  localparam logic [7:0] CTRL_MASK = 8'h6F;
`else
  localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

  logic [7:0]  ctrl_q;
  logic [15:0] div_q, eff_div, half_div, off;
  logic [4:0]  key_q;
  logic [2:0]  sel;
  logic        first, rd_first, wr_first, stat_rd;
  logic        re, rie, tie, pen, podd;
  logic        ovr_q, fe_q, pe_q, txovf_q, ovr_set, fe_set, pe_set, txovf_set;
  logic [7:0]  rxf_mem [FIFO_DEPTH];
  logic [7:0]  txf_mem [FIFO_DEPTH];
  logic [AW:0] rxf_wp_q, rxf_rp_q, txf_wp_q, txf_rp_q;
  logic        rxf_empty, rxf_full, rxf_pop, rxf_push;
  logic        txf_empty, txf_full, txf_pop, txf_push, txf_push_req;
  logic [2:0]  tx_state_q, tx_bit_q, rx_state_q, rx_bit_q;
  logic [15:0] tx_cnt_q, rx_cnt_q;
  logic [7:0]  tx_sh_q, rx_sh_q, stat, rx_head;
  logic        tx_par_q, tx_q, tx_line, tx_load;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_push_q;

  // A new access starts whenever the (window, register, direction) key changes.
  assign off      = mcu_ad - BASE;
  assign en_sci   = off < 16'd5;
  assign sel      = off[2:0];
  assign first    = en_sci && (key_q != {1'b1, sel, mcu_wr});
  assign rd_first = first && !mcu_wr;
  assign wr_first = first && mcu_wr;
  assign stat_rd  = rd_first && (sel == A_STAT);

  assign re  = ctrl_q[0];
  assign te  = ctrl_q[1];
  assign rie = ctrl_q[2];
  assign tie = ctrl_q[3];
`ifdef SCI_PARITY_EN
  assign pen  = ctrl_q[5];
  assign podd = ctrl_q[6];
`else
  assign pen  = 1'b0;
  assign podd = 1'b0;
`endif

  // Periods below 4 clocks are clamped; counting eff_div..0 gives eff_div+1 clocks,
  // so DIV=16'hFFFF yields 65536 without a wider counter.
  assign eff_div  = (div_q < 16'd3) ? 16'd3 : div_q;
  assign half_div = {1'b0, eff_div[15:1]} + {15'd0, eff_div[0]};

  // Control/divider registers and the access-edge key.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      ctrl_q <= 8'h00;
      div_q  <= DIV_RESET;
      key_q  <= 5'd0;
    end else begin
      key_q <= {en_sci, sel, mcu_wr};
      if (wr_first) begin
        case (sel)
          A_CTRL:  ctrl_q      <= mcu_do & CTRL_MASK;
          A_DIVL:  div_q[7:0]  <= mcu_do;
          A_DIVH:  div_q[15:8] <= mcu_do;
          default: ;
        endcase
      end
    end
  end

  // FIFO status and arbitration; a same-cycle pop frees the slot for the push.
  assign rxf_empty    = rxf_wp_q == rxf_rp_q;
  assign rxf_full     = (rxf_wp_q[AW] != rxf_rp_q[AW]) && (rxf_wp_q[AW-1:0] == rxf_rp_q[AW-1:0]);
  assign txf_empty    = txf_wp_q == txf_rp_q;
  assign txf_full     = (txf_wp_q[AW] != txf_rp_q[AW]) && (txf_wp_q[AW-1:0] == txf_rp_q[AW-1:0]);
  assign rxf_pop      = rd_first && (sel == A_DATA) && !rxf_empty;
  assign rxf_push     = rx_push_q && (!rxf_full || rxf_pop);
  assign ovr_set      = rx_push_q && rxf_full && !rxf_pop;
  assign txf_push_req = wr_first && (sel == A_DATA);
  assign txf_push     = txf_push_req && (!txf_full || txf_pop);
  assign txovf_set    = txf_push_req && txf_full && !txf_pop;
  assign tx_load      = te && !txf_empty &&
                        ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_cnt_q == 16'd0)));
  assign txf_pop      = tx_load;
  assign rx_head      = rxf_empty ? 8'h00 : rxf_mem[rxf_rp_q[AW-1:0]];

  // FIFO pointers.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      rxf_wp_q <= '0;
      rxf_rp_q <= '0;
      txf_wp_q <= '0;
      txf_rp_q <= '0;
    end else begin
      if (rxf_push) rxf_wp_q <= rxf_wp_q + PTR_ONE;
      if (rxf_pop)  rxf_rp_q <= rxf_rp_q + PTR_ONE;
      if (txf_push) txf_wp_q <= txf_wp_q + PTR_ONE;
      if (txf_pop)  txf_rp_q <= txf_rp_q + PTR_ONE;
    end
  end

  // FIFO storage (no reset needed; pointers define validity).
  always_ff @(posedge mcu_clx2) begin
    if (rxf_push) rxf_mem[rxf_wp_q[AW-1:0]] <= rx_sh_q;
    if (txf_push) txf_mem[txf_wp_q[AW-1:0]] <= mcu_do;
  end

  // Sticky error flags: a set in the same cycle as the clearing read wins.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      txovf_q <= 1'b0;
    end else begin
      ovr_q   <= ovr_set   | (ovr_q   & ~stat_rd);
      fe_q    <= fe_set    | (fe_q    & ~stat_rd);
      pe_q    <= pe_set    | (pe_q    & ~stat_rd);
      txovf_q <= txovf_set | (txovf_q & ~stat_rd);
    end
  end

  // TX line level for the current state; registered so tx falls one clock after the pop.
  always_comb begin
    tx_line = 1'b1;
    case (tx_state_q)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_sh_q[0];
      S_PAR:   tx_line = tx_par_q;
      default: tx_line = 1'b1;
    endcase
  end

  // TX FSM with bit down-counter.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_q <= tx_line;
      if (tx_load) begin
        tx_sh_q    <= txf_mem[txf_rp_q[AW-1:0]];
        tx_par_q   <= podd ^ (^txf_mem[txf_rp_q[AW-1:0]]);
        tx_cnt_q   <= eff_div;
        tx_state_q <= S_START;
      end else if (tx_state_q == S_IDLE) begin
        tx_state_q <= S_IDLE;
      end else if (tx_cnt_q != 16'd0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= eff_div;
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            tx_bit_q   <= 3'd0;
          end
          S_DATA: begin
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_q <= pen ? S_PAR : S_STOP;
          end
          S_PAR:   tx_state_q <= S_STOP;
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_fall = rx_prev_q && !rx_s2_q;
  assign fe_set  = re && (rx_state_q == S_STOP) && (rx_cnt_q == 16'd0) && !rx_s2_q;
  assign pe_set  = re && (rx_state_q == S_PAR) && (rx_cnt_q == 16'd0) &&
                   (rx_s2_q != (podd ^ (^rx_sh_q)));

  // RX synchroniser and FSM; RE=0 parks the FSM in IDLE without touching the FIFO.
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_push_q  <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_push_q <= 1'b0;
      if (!re) begin
        rx_state_q <= S_IDLE;
      end else if (rx_state_q == S_IDLE) begin
        if (rx_fall) begin
          rx_state_q <= S_START;
          rx_cnt_q   <= half_div;
        end
      end else if (rx_cnt_q != 16'd0) begin
        rx_cnt_q <= rx_cnt_q - 16'd1;
      end else begin
        rx_cnt_q <= eff_div;
        case (rx_state_q)
          S_START: begin
            rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
            rx_bit_q   <= 3'd0;
          end
          S_DATA: begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= pen ? S_PAR : S_STOP;
          end
          S_PAR: rx_state_q <= S_STOP;
          S_STOP: begin
            rx_push_q  <= 1'b1;
            rx_state_q <= S_IDLE;
          end
          default: rx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign stat = {txovf_q, pe_q, fe_q, ovr_q, ~txf_full,
                 txf_empty && (tx_state_q == S_IDLE), rxf_full, ~rxf_empty};
  assign tx   = tx_q;
  assign mcu_irq2_sci = (rie && (~rxf_empty || ovr_q || fe_q || pe_q)) || (tie && ~txf_full);

  // Combinational read mux; zero outside the window.
  always_comb begin
    iod = 8'h00;
    if (en_sci) begin
      case (sel)
        A_CTRL:  iod = ctrl_q;
        A_STAT:  iod = stat;
        A_DATA:  iod = rx_head;
        A_DIVL:  iod = div_q[7:0];
        A_DIVH:  iod = div_q[15:8];
        default: iod = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_hd63701_sci_fifo.sv
// Directed bench for hd63701_sci_fifo (FIFO_DEPTH=4, BASE=16'h0010).
module tb_hd63701_sci_fifo;
  localparam logic [15:0] BASE = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ad = 16'h0000;
  logic        wr = 1'b0;
  logic [7:0]  dout = 8'h00;
  logic        rx = 1'b1;
  logic        tx, te, irq, en;
  logic [7:0]  iod;
  int          checks = 0;
  int          failures = 0;

  hd63701_sci_fifo #(.BASE(BASE), .FIFO_DEPTH(4), .DIV_RESET(16'd255)) dut (
    .mcu_clx2(clk), .mcu_rst_n(rst_n), .mcu_ad(ad), .mcu_wr(wr), .mcu_do(dout),
    .rx(rx), .tx(tx), .te(te), .mcu_irq2_sci(irq), .en_sci(en), .iod(iod));

  always #5 clk = ~clk;

  task automatic write_reg(input logic [2:0] o, input logic [7:0] d);
    @(negedge clk);
    ad = BASE + {13'd0, o}; wr = 1'b1; dout = d;
    @(negedge clk);
    ad = 16'h0000; wr = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] o, output logic [7:0] d);
    @(negedge clk);
    ad = BASE + {13'd0, o}; wr = 1'b0;
    #1 d = iod;
    @(negedge clk);
    ad = 16'h0000;
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_b, input logic has_par,
                         input logic par_b, input int period);
    @(negedge clk);
    rx = 1'b0; repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = d[i]; repeat (period) @(negedge clk); end
    if (has_par) begin rx = par_b; repeat (period) @(negedge clk); end
    rx = stop_b; repeat (period) @(negedge clk);
    rx = 1'b1;
  endtask

  // Called right after the clock edge that pushed the byte / set TE (k=0).
  task automatic watch_tx(input int period, input int nframes, input int nbits,
                          input logic podd, input logic [31:0] bytes);
    int total, f, b;
    logic [7:0] d;
    logic e;
    total = period * nbits * nframes;
    ad = BASE + 16'd1; wr = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL tx_latency_k1 got=%b exp=1", tx); end
      end
      if (k == 2) begin
        checks++; if (tx !== 1'b0) begin failures++; $display("FAIL tx_latency_k2 got=%b exp=0", tx); end
      end
      if (k >= 2 && k < 2 + total && ((k - 2) % period) == period / 2) begin
        f = (k - 2) / (period * nbits);
        b = ((k - 2) / period) % nbits;
        d = bytes[8*f +: 8];
        if (b == 0) e = 1'b0;
        else if (b <= 8) e = d[b-1];
        else if (b == nbits - 1) e = 1'b1;
        else e = podd ^ (^d);
        checks++;
        if (tx !== e) begin failures++; $display("FAIL tx_bit frame=%0d bit=%0d got=%b exp=%b", f, b, tx, e); end
      end
      if (k == total) begin
        checks++; if (iod[2] !== 1'b0) begin failures++; $display("FAIL txe_busy got=%b exp=0", iod[2]); end
      end
      if (k == total + 1) begin
        checks++; if (iod[2] !== 1'b1) begin failures++; $display("FAIL txe_done got=%b exp=1", iod[2]); end
      end
    end
    ad = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk); #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (te !== 1'b0) begin failures++; $display("FAIL reset_te got=%b exp=0", te); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rst_n = 1'b1;
    @(negedge clk);
    ad = BASE - 16'd1; #1;
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL en_below got=%b exp=0", en); end
    checks++; if (iod !== 8'h00) begin failures++; $display("FAIL iod_outside got=%h exp=00", iod); end
    ad = BASE + 16'd4; #1;
    checks++; if (en !== 1'b1) begin failures++; $display("FAIL en_top got=%b exp=1", en); end
    ad = BASE + 16'd5; #1;
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL en_above got=%b exp=0", en); end
    ad = 16'h0000;
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0C) begin failures++; $display("FAIL reset_stat got=%h exp=0c", v); end
    read_reg(3'd0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_ctrl got=%h exp=00", v); end
    read_reg(3'd3, v);
    checks++; if (v !== 8'hFF) begin failures++; $display("FAIL reset_divl got=%h exp=ff", v); end
    read_reg(3'd4, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_divh got=%h exp=00", v); end
    read_reg(3'd2, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL empty_data got=%h exp=00", v); end
    write_reg(3'd0, 8'h08); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL tie_irq got=%b exp=1", irq); end
    write_reg(3'd0, 8'h00); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL tie_off_irq got=%b exp=0", irq); end
  endtask

  task automatic test_tx_default();
    write_reg(3'd0, 8'h02); #1;
    checks++; if (te !== 1'b1) begin failures++; $display("FAIL te_pin got=%b exp=1", te); end
    write_reg(3'd2, 8'hA5);
    watch_tx(256, 1, 10, 1'b0, 32'h0000_00A5);
  endtask

  task automatic test_tx_overflow();
    logic [7:0] v;
    write_reg(3'd0, 8'h00);
    write_reg(3'd3, 8'h03);
    write_reg(3'd2, 8'h11);
    write_reg(3'd2, 8'h22);
    write_reg(3'd2, 8'h33);
    write_reg(3'd2, 8'h44);
    write_reg(3'd2, 8'h55);
    read_reg(3'd1, v);
    checks++; if (v !== 8'h80) begin failures++; $display("FAIL txovf_stat got=%h exp=80", v); end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL txovf_cleared got=%h exp=00", v); end
    write_reg(3'd0, 8'h02);
    watch_tx(4, 4, 10, 1'b0, 32'h4433_2211);
  endtask

  task automatic test_rx_basic();
    logic [7:0] v;
    write_reg(3'd0, 8'h05);
    write_reg(3'd3, 8'h0F);
    rx_send(8'h3C, 1'b1, 1'b0, 1'b0, 16);
    rx_send(8'h7E, 1'b1, 1'b0, 1'b0, 16);
    repeat (10) @(negedge clk); #1;
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq got=%b exp=1", irq); end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0D) begin failures++; $display("FAIL rx_stat got=%h exp=0d", v); end
    @(negedge clk); ad = BASE + 16'd2; wr = 1'b0; #1;
    checks++; if (iod !== 8'h3C) begin failures++; $display("FAIL held_rd0 got=%h exp=3c", iod); end
    @(negedge clk); #1;
    checks++; if (iod !== 8'h7E) begin failures++; $display("FAIL held_rd1 got=%h exp=7e", iod); end
    @(negedge clk); #1;
    checks++; if (iod !== 8'h7E) begin failures++; $display("FAIL held_rd2 got=%h exp=7e", iod); end
    @(negedge clk); ad = 16'h0000;
    read_reg(3'd2, v);
    checks++; if (v !== 8'h7E) begin failures++; $display("FAIL rx_second got=%h exp=7e", v); end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0C) begin failures++; $display("FAIL rx_drained got=%h exp=0c", v); end
    #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_off got=%b exp=0", irq); end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] v;
    logic [7:0] exp_b;
    for (int i = 1; i <= 5; i++) rx_send(i[7:0], 1'b1, 1'b0, 1'b0, 16);
    repeat (10) @(negedge clk);
    read_reg(3'd1, v);
    checks++; if (v !== 8'h1F) begin failures++; $display("FAIL ovr_stat got=%h exp=1f", v); end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0F) begin failures++; $display("FAIL ovr_cleared got=%h exp=0f", v); end
    for (int i = 1; i <= 5; i++) begin
      exp_b = (i <= 4) ? i[7:0] : 8'h00;
      read_reg(3'd2, v);
      checks++; if (v !== exp_b) begin failures++; $display("FAIL ovr_data idx=%0d got=%h exp=%h", i, v, exp_b); end
    end
  endtask

  task automatic test_rx_framing();
    logic [7:0] v;
    rx_send(8'h5A, 1'b0, 1'b0, 1'b0, 16);
    repeat (20) @(negedge clk);
    read_reg(3'd1, v);
    checks++; if (v !== 8'h2D) begin failures++; $display("FAIL fe_stat got=%h exp=2d", v); end
    read_reg(3'd2, v);
    checks++; if (v !== 8'h5A) begin failures++; $display("FAIL fe_data got=%h exp=5a", v); end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0C) begin failures++; $display("FAIL fe_cleared got=%h exp=0c", v); end
  endtask

  task automatic test_rx_glitch();
    logic [7:0] v;
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (60) @(negedge clk); #1;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0C) begin failures++; $display("FAIL glitch_stat got=%h exp=0c", v); end
  endtask

`ifdef SCI_PARITY_EN
  task automatic test_parity();
    logic [7:0] v;
    write_reg(3'd0, 8'h62);
    read_reg(3'd0, v);
    checks++; if (v !== 8'h62) begin failures++; $display("FAIL par_ctrl got=%h exp=62", v); end
    write_reg(3'd2, 8'h01);
    watch_tx(16, 1, 11, 1'b1, 32'h0000_0001);
    write_reg(3'd0, 8'h61);
    rx_send(8'h01, 1'b1, 1'b1, 1'b1, 16);
    repeat (10) @(negedge clk);
    read_reg(3'd1, v);
    checks++; if (v !== 8'h4D) begin failures++; $display("FAIL pe_stat got=%h exp=4d", v); end
    read_reg(3'd2, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL pe_data got=%h exp=01", v); end
    rx_send(8'h03, 1'b1, 1'b1, 1'b1, 16);
    repeat (10) @(negedge clk);
    read_reg(3'd1, v);
    checks++; if (v !== 8'h0D) begin failures++; $display("FAIL par_ok_stat got=%h exp=0d", v); end
    read_reg(3'd2, v);
    checks++; if (v !== 8'h03) begin failures++; $display("FAIL par_ok_data got=%h exp=03", v); end
  endtask
`else
  task automatic test_parity();
    logic [7:0] v;
    write_reg(3'd0, 8'h60);
    read_reg(3'd0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL nopar_ctrl got=%h exp=00", v); end
    write_reg(3'd0, 8'hFF);
    read_reg(3'd0, v);
    checks++; if (v !== 8'h0F) begin failures++; $display("FAIL nopar_mask got=%h exp=0f", v); end
    write_reg(3'd0, 8'h00);
  endtask
`endif

  task automatic test_div_clamp();
    logic [7:0] v;
    write_reg(3'd3, 8'h01);
    read_reg(3'd3, v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL divl_raw got=%h exp=01", v); end
    write_reg(3'd0, 8'h02);
    write_reg(3'd2, 8'h96);
    watch_tx(4, 1, 10, 1'b0, 32'h0000_0096);
  endtask

  task automatic test_te_midframe();
    logic [7:0] v;
    write_reg(3'd2, 8'hC3);
    write_reg(3'd2, 8'h3C);
    repeat (8) @(negedge clk);
    write_reg(3'd0, 8'h00);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(negedge clk); #1;
      checks++; if (tx !== 1'b1) begin failures++; $display("FAIL te_off_tx idx=%0d got=%b exp=1", i, tx); end
    end
    read_reg(3'd1, v);
    checks++; if (v !== 8'h08) begin failures++; $display("FAIL te_off_stat got=%h exp=08", v); end
  endtask

  initial begin
    test_reset();
    test_tx_default();
    test_tx_overflow();
    test_rx_basic();
    test_rx_overrun();
    test_rx_framing();
    test_rx_glitch();
    test_parity();
    test_div_clamp();
    test_te_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
